// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the instruction
// memory (slave): one request channel and one in-order response channel.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time, buffers the
// returned instruction for decode, and handles redirects and halts.
// Responses that belong to a request made before a redirect are dropped
// through the kill flag, so the memory never has to be told to abort.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  output logic [31:0]  instruction,
  output logic [31:0]  inst_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  input  logic         jump_enable,
  input  logic [31:0]  jump_target,
  input  logic [1:0]   debug,
  output logic         halted,
  output logic         fetch_fault
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] req_pc_r;
  logic        kill_r;
  logic [31:0] buf_data_r;
  logic [31:0] buf_pc_r;
  logic        buf_valid_r;
  logic        halted_r;
  logic        fault_r;

  logic        halt_req_s;
  logic        misalign_s;
  logic        issue_s;
  logic        accept_s;
  logic        consume_s;

  // A halt code only counts while decode is actually looking at an instruction.
  assign halt_req_s = buf_valid_r && ((debug == 2'b01) || (debug == 2'b10));
  assign misalign_s = jump_enable && (jump_target[1:0] != 2'b00);
  // Redirects and halts take the cycle; otherwise issue when the buffer has room.
  assign issue_s    = (state_r == ST_RUN) && !reset && !jump_enable && !halt_req_s &&
                      (!buf_valid_r || inst_ready);
  assign accept_s   = issue_s && imem.imem_req_ready;
  assign consume_s  = buf_valid_r && inst_ready;

  assign imem.imem_req_valid = issue_s;
  assign imem.imem_req_addr  = pc_r;
  assign instruction         = buf_data_r;
  assign inst_pc             = buf_pc_r;
  assign inst_valid          = buf_valid_r;
  assign halted              = halted_r;
  assign fetch_fault         = fault_r;

  // Fetch sequencer: request issue, response capture, redirect and halt handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      req_pc_r    <= RESET_PC;
      kill_r      <= 1'b0;
      buf_data_r  <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
      buf_valid_r <= 1'b0;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_WAIT: begin
          if (halt_req_s) begin
            // Buffer contents stay visible for debug; only the valid drops.
            state_r     <= ST_HALT;
            halted_r    <= 1'b1;
            buf_valid_r <= 1'b0;
            kill_r      <= 1'b0;
          end else if (misalign_s) begin
            state_r     <= ST_HALT;
            halted_r    <= 1'b1;
            fault_r     <= 1'b1;
            buf_valid_r <= 1'b0;
            kill_r      <= 1'b0;
          end else if (jump_enable) begin
            pc_r        <= jump_target;
            buf_valid_r <= 1'b0;
            if ((state_r == ST_WAIT) && !imem.imem_resp_valid) begin
              // Stale response still in flight: drop it when it arrives.
              kill_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              kill_r  <= 1'b0;
            end
          end else if (state_r == ST_RUN) begin
            if (consume_s) begin
              buf_valid_r <= 1'b0;
            end
            if (accept_s) begin
              req_pc_r <= pc_r;
              pc_r     <= pc_r + 32'd4;
              state_r  <= ST_WAIT;
            end
          end else if (imem.imem_resp_valid) begin
            state_r <= ST_RUN;
            kill_r  <= 1'b0;
            if (!kill_r) begin
              // Refill wins over a same-cycle consume.
              buf_data_r  <= imem.imem_resp_data;
              buf_pc_r    <= req_pc_r;
              buf_valid_r <= 1'b1;
            end else if (consume_s) begin
              buf_valid_r <= 1'b0;
            end
          end else if (consume_s) begin
            buf_valid_r <= 1'b0;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          // Unreachable encoding: stop fetching rather than guess.
          state_r     <= ST_HALT;
          halted_r    <= 1'b1;
          buf_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
